usm_row_accumulator: RTL and testbench

Vertical-reduction stage of the USM convolution path and the consumer of the row-convolution partial-sum stream. It accepts one partial-sum vector per kernel row, accumulates COV_SIZE consecutive rows per lane into a full 2-D kernel sum, then normalizes by right shift and saturates to pixel width. Results are presented on a single-entry valid/ready output buffer. The upstream row convolver has no backpressure, so overruns are flagged rather than stalled.

---
 rtl/usm_row_accumulator_pkg.sv | 19 +
 rtl/usm_row_accumulator_if.sv | 24 ++
 rtl/usm_row_accumulator_norm_sat.sv | 35 +++
 rtl/usm_row_accumulator.sv | 104 ++++++++++
 tb/tb_usm_row_accumulator.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usm_row_accumulator_pkg.sv
// Shared USM constants and helpers for the row accumulator.
// Optional rounding is selected with the USM_ACC_ROUND_EN macro in usm_norm_sat.
package usm_row_accumulator_pkg;

    localparam int DEFAULT_SHIFT     = 8;
    localparam int DEFAULT_OUT_WIDTH = 8;

    // Sum of cov_size unsigned values of psum_width bits never needs more bits than this.
    function automatic int acc_width(input int psum_width, input int cov_size);
        return psum_width + $clog2(cov_size);
    endfunction

    function automatic logic [63:0] saturate(input logic [63:0] value, input int unsigned width);
        logic [63:0] limit;
        limit = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/usm_row_accumulator_if.sv
// Partial-sum input strobe and valid/ready result bus of the row accumulator.
interface usm_row_accumulator_if
    import usm_row_accumulator_pkg::*;
#(
    parameter int OUTPUT_LENGTH = 8,
    parameter int PSUM_WIDTH    = 18,
    parameter int OUT_WIDTH     = DEFAULT_OUT_WIDTH
);
    logic                                psum_valid;
    logic [OUTPUT_LENGTH*PSUM_WIDTH-1:0] psum_vector;
    logic                                out_valid;
    logic                                out_ready;
    logic [OUTPUT_LENGTH*OUT_WIDTH-1:0]  out_pixels;

    modport master (
        output psum_valid, psum_vector, out_ready,
        input  out_valid, out_pixels
    );

    modport slave (
        input  psum_valid, psum_vector, out_ready,
        output out_valid, out_pixels
    );
endinterface

// File: rtl/usm_row_accumulator_norm_sat.sv
// Combinational per-lane normalize (shift, optional round-half-up) and clamp.
// Rounding is enabled by defining USM_ACC_ROUND_EN; SHIFT = 0 always passes through.
module usm_norm_sat
    import usm_row_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 20,
    parameter int SHIFT     = DEFAULT_SHIFT,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] sum,
    output logic [OUT_WIDTH-1:0] pixel
);
    // One extra bit so the rounding add cannot wrap.
    logic [ACC_WIDTH:0] shifted;

    generate
`ifdef USM_ACC_ROUND_EN
        if (SHIFT > 0) begin : g_round
            localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
            assign shifted = ({1'b0, sum} + HALF) >> SHIFT;
        end else begin : g_pass
            assign shifted = {1'b0, sum};
        end
`else
        if (SHIFT > 0) begin : g_trunc
            assign shifted = {1'b0, sum} >> SHIFT;
        end else begin : g_pass
            assign shifted = {1'b0, sum};
        end
`endif
    endgenerate

    assign pixel = OUT_WIDTH'(saturate(64'(shifted), OUT_WIDTH));

endmodule

// File: rtl/usm_row_accumulator.sv
// Vertical reduction of COV_SIZE row partial sums per lane into normalized pixels,
// presented on a single-entry valid/ready buffer; rounding via USM_ACC_ROUND_EN.
module usm_row_accumulator
    import usm_row_accumulator_pkg::*;
#(
    parameter int OUTPUT_LENGTH = 8,
    parameter int COV_SIZE      = 3,
    parameter int PSUM_WIDTH    = 18,
    parameter int SHIFT         = DEFAULT_SHIFT,
    parameter int OUT_WIDTH     = DEFAULT_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    usm_row_accumulator_if.slave          bus,
    output logic [$clog2(COV_SIZE)-1:0]   row_cnt,
    output logic                          ovf_err
);
    localparam int ACC_WIDTH = acc_width(PSUM_WIDTH, COV_SIZE);
    localparam int CNT_WIDTH = $clog2(COV_SIZE);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(COV_SIZE - 1);

    logic [ACC_WIDTH-1:0]               acc       [OUTPUT_LENGTH];
    logic [ACC_WIDTH-1:0]               psum_lane [OUTPUT_LENGTH];
    logic [ACC_WIDTH-1:0]               sum_lane  [OUTPUT_LENGTH];
    logic [OUTPUT_LENGTH*OUT_WIDTH-1:0] result;
    logic [OUTPUT_LENGTH*OUT_WIDTH-1:0] out_pixels;
    logic                               out_valid;

    logic take_row;
    logic last_row;
    logic complete;
    logic accept;
    logic load;

    // The upstream convolver cannot stall, so clear simply drops a coincident row.
    assign take_row = bus.psum_valid & ~clear;
    assign last_row = (row_cnt == LAST_ROW);
    assign complete = take_row & last_row;
    assign accept   = out_valid & bus.out_ready;
    assign load     = complete & (~out_valid | bus.out_ready);

    generate
        for (genvar i = 0; i < OUTPUT_LENGTH; i++) begin : g_lane
            assign psum_lane[i] = ACC_WIDTH'(bus.psum_vector[i*PSUM_WIDTH +: PSUM_WIDTH]);
            // Only read on the last row, when acc[i] always holds the earlier rows.
            assign sum_lane[i]  = acc[i] + psum_lane[i];

            usm_norm_sat #(
                .ACC_WIDTH (ACC_WIDTH),
                .SHIFT     (SHIFT),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_norm_sat (
                .sum   (sum_lane[i]),
                .pixel (result[i*OUT_WIDTH +: OUT_WIDTH])
            );
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt    <= '0;
            ovf_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_pixels <= '0;
            // NOTE: the accumulator array is reset too, so no stale partial rows
            // survive a reset even though row_cnt == 0 would mask them.
            for (int i = 0; i < OUTPUT_LENGTH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (clear) begin
                row_cnt <= '0;
                ovf_err <= 1'b0;
            end else if (bus.psum_valid) begin
                if (last_row) begin
                    row_cnt <= '0;
                    if (!load) begin
                        ovf_err <= 1'b1;
                    end
                end else begin
                    row_cnt <= row_cnt + CNT_WIDTH'(1);
                    for (int i = 0; i < OUTPUT_LENGTH; i++) begin
                        acc[i] <= ((row_cnt == '0) ? '0 : acc[i]) + psum_lane[i];
                    end
                end
            end

            // The output buffer ignores clear; only load and accept move it.
            if (load) begin
                out_valid  <= 1'b1;
                out_pixels <= result;
            end else if (accept) begin
                out_valid  <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_pixels = out_pixels;

endmodule

// File: tb/tb_usm_row_accumulator.sv
// Self-checking bench for usm_row_accumulator: directed scenarios plus a randomized
// run scored against a row-group / output-buffer model.
module tb_usm_row_accumulator;
    localparam int OUTPUT_LENGTH = 2;
    localparam int COV_SIZE      = 3;
    localparam int PSUM_WIDTH    = 18;
    localparam int SHIFT         = 4;
    localparam int OUT_WIDTH     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [1:0] row_cnt;
    logic       ovf_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    usm_row_accumulator_if #(
        .OUTPUT_LENGTH (OUTPUT_LENGTH),
        .PSUM_WIDTH    (PSUM_WIDTH),
        .OUT_WIDTH     (OUT_WIDTH)
    ) bus ();

    usm_row_accumulator #(
        .OUTPUT_LENGTH (OUTPUT_LENGTH),
        .COV_SIZE      (COV_SIZE),
        .PSUM_WIDTH    (PSUM_WIDTH),
        .SHIFT         (SHIFT),
        .OUT_WIDTH     (OUT_WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .bus     (bus),
        .row_cnt (row_cnt),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    // Reference normalization: integer divide by 2^SHIFT, then clamp to pixel range.
    function automatic int exp_pix(input int sum);
        int n;
`ifdef USM_ACC_ROUND_EN
        n = (sum + (2 ** SHIFT) / 2) / (2 ** SHIFT);
`else
        n = sum / (2 ** SHIFT);
`endif
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int lane(input int idx);
        logic [15:0] pix;
        pix = bus.out_pixels;
        return (idx == 0) ? int'(pix[7:0]) : int'(pix[15:8]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear = 1'b0;
        bus.psum_valid  = 1'b0;
        bus.psum_vector = '0;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic row(input int l0, input int l1);
        @(negedge clk);
        bus.psum_valid  = 1'b1;
        bus.psum_vector = {18'(l1), 18'(l0)};
    endtask

    task automatic idle();
        @(negedge clk);
        bus.psum_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_pixels !== 16'h0) $display("FAIL reset_out_pixels got %0h expected 0", bus.out_pixels);
        else pass_cnt++;
        total_cnt++;
        if (row_cnt !== 2'd0) $display("FAIL reset_row_cnt got %0d expected 0", row_cnt);
        else pass_cnt++;
        total_cnt++;
        if (ovf_err !== 1'b0) $display("FAIL reset_ovf_err got %0b expected 0", ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        row(100, 1);
        row(200, 2);
        row(300, 3);
        total_cnt++;
        if (row_cnt !== 2'd2) $display("FAIL basic_row_cnt got %0d expected 2", row_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b expected 0", bus.out_valid);
        else pass_cnt++;
        idle();
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %0b expected 1", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (lane(0) !== exp_pix(600)) $display("FAIL basic_lane0 got %0d expected %0d", lane(0), exp_pix(600));
        else pass_cnt++;
        total_cnt++;
        if (lane(1) !== 0) $display("FAIL basic_lane1 got %0d expected 0", lane(1));
        else pass_cnt++;
        total_cnt++;
        if (row_cnt !== 2'd0) $display("FAIL basic_row_cnt_wrap got %0d expected 0", row_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        row(2000, 0);
        row(2000, 0);
        row(2000, 0);
        idle();
        total_cnt++;
        if (lane(0) !== 255) $display("FAIL sat_lane0 got %0d expected 255", lane(0));
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        row(160, 16); row(160, 16); row(160, 16);
        row(320, 0);  row(320, 0);  row(320, 0);
        idle();
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL bp_valid got %0b expected 1", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (lane(0) !== 30 || lane(1) !== 3)
            $display("FAIL bp_held got %0d,%0d expected 30,3", lane(0), lane(1));
        else pass_cnt++;
        total_cnt++;
        if (ovf_err !== 1'b1) $display("FAIL bp_ovf_err got %0b expected 1", ovf_err);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_accept got %0b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (lane(0) !== 30) $display("FAIL bp_pixels_hold got %0d expected 30", lane(0));
        else pass_cnt++;
        clear = 1'b1;
        idle();
        total_cnt++;
        if (ovf_err !== 1'b0) $display("FAIL bp_clear_ovf got %0b expected 0", ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_accept_and_load();
        do_reset();
        row(160, 16); row(160, 16); row(160, 16);
        row(320, 32); row(320, 32); row(320, 32);
        bus.out_ready = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL al_valid got %0b expected 1", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (lane(0) !== 60 || lane(1) !== 6)
            $display("FAIL al_pixels got %0d,%0d expected 60,6", lane(0), lane(1));
        else pass_cnt++;
        total_cnt++;
        if (ovf_err !== 1'b0) $display("FAIL al_ovf_err got %0b expected 0", ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_group();
        do_reset();
        row(500, 500);
        row(500, 500);
        idle();
        do_reset();
        total_cnt++;
        if (row_cnt !== 2'd0) $display("FAIL rmg_row_cnt got %0d expected 0", row_cnt);
        else pass_cnt++;
        row(16, 0); row(16, 0); row(16, 0);
        idle();
        total_cnt++;
        if (lane(0) !== 3 || lane(1) !== 0)
            $display("FAIL rmg_pixels got %0d,%0d expected 3,0", lane(0), lane(1));
        else pass_cnt++;
    endtask

    task automatic test_clear();
        do_reset();
        row(160, 0);
        row(160, 0);
        clear = 1'b1;
        idle();
        total_cnt++;
        if (row_cnt !== 2'd0) $display("FAIL clr_row_cnt got %0d expected 0", row_cnt);
        else pass_cnt++;
        row(160, 0); row(160, 0); row(160, 0);
        idle();
        total_cnt++;
        if (lane(0) !== 30) $display("FAIL clr_lane0 got %0d expected 30", lane(0));
        else pass_cnt++;
        total_cnt++;
        if (ovf_err !== 1'b0) $display("FAIL clr_ovf_err got %0b expected 0", ovf_err);
        else pass_cnt++;
    endtask

    // Randomized back-to-back strobes and random out_ready against a group/buffer model.
    task automatic test_random();
        int m_rows;
        int m_sum [2];
        int m_pix [2];
        bit m_valid;
        bit m_ovf;
        int errs;
        do_reset();
        m_rows = 0; m_sum = '{0, 0}; m_pix = '{0, 0}; m_valid = 0; m_ovf = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit v;
            bit rdy;
            int l [2];
            @(negedge clk);
            errs = 0;
            if (bus.out_valid !== m_valid) errs++;
            if (lane(0) !== m_pix[0] || lane(1) !== m_pix[1]) errs++;
            if (int'(row_cnt) !== m_rows) errs++;
            if (ovf_err !== m_ovf) errs++;
            total_cnt++;
            if (errs != 0)
                $display("FAIL rand_cycle%0d got v=%0b pix=%0d,%0d rc=%0d ovf=%0b expected v=%0b pix=%0d,%0d rc=%0d ovf=%0b",
                         cyc, bus.out_valid, lane(0), lane(1), row_cnt, ovf_err,
                         m_valid, m_pix[0], m_pix[1], m_rows, m_ovf);
            else pass_cnt++;

            v    = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 2) == 0);
            l[0] = $urandom_range(0, 2 ** PSUM_WIDTH - 1);
            l[1] = (cyc % 7 == 0) ? $urandom_range(0, 8000) : $urandom_range(0, 2 ** PSUM_WIDTH - 1);
            bus.psum_valid  = v;
            bus.psum_vector = {18'(l[1]), 18'(l[0])};
            bus.out_ready   = rdy;

            if (v && m_rows == COV_SIZE - 1) begin
                if (!m_valid || rdy) begin
                    m_valid = 1;
                    m_pix[0] = exp_pix(m_sum[0] + l[0]);
                    m_pix[1] = exp_pix(m_sum[1] + l[1]);
                end else begin
                    m_ovf = 1;
                end
                m_rows = 0;
                m_sum = '{0, 0};
            end else begin
                if (m_valid && rdy) m_valid = 0;
                if (v) begin
                    m_sum[0] += l[0];
                    m_sum[1] += l[1];
                    m_rows++;
                end
            end
        end
        idle();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.psum_valid  = 1'b0;
        bus.psum_vector = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_accept_and_load();
        test_reset_mid_group();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
